// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg_pkg
// Stage field widths, per-boundary pipe widths and occupancy state encoding.
// Revision: 1.0
// ============================================================================
package pipe_stage_reg_pkg;

  localparam int ADDRESS_LEN         = 32;
  localparam int REGISTER_LEN        = 32;
  localparam int REG_ADDR_LEN        = 5;
  localparam int EXECUTE_COMMAND_LEN = 8;
  localparam int MEM_COMMAND_LEN     = 4;
  localparam int WB_COMMAND_LEN      = 2;

  // Control/data width pair for each stage boundary.
  localparam int IDEX_PIPE_CTRL_W  = EXECUTE_COMMAND_LEN;
  localparam int IDEX_PIPE_DATA_W  = ADDRESS_LEN + 2 * REGISTER_LEN;
  localparam int EXMEM_PIPE_CTRL_W = MEM_COMMAND_LEN + WB_COMMAND_LEN;
  localparam int EXMEM_PIPE_DATA_W = 2 * REGISTER_LEN + REG_ADDR_LEN;
  localparam int MEMWB_PIPE_CTRL_W = WB_COMMAND_LEN;
  localparam int MEMWB_PIPE_DATA_W = REGISTER_LEN + REG_ADDR_LEN;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
// pipe_entry_reg
// One valid+ctrl+data entry with clear and load; ctrl is zero when invalid.
// Revision: 1.0
// ============================================================================
module pipe_entry_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= valid_i;
      ctrl_q  <= valid_i ? ctrl_i : '0;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg
// Valid/ready pipeline stage register with optional skid entry, flush and
// saturating stall-cycle counter.
// Revision: 1.0
// ============================================================================
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  occ_e              state_q;
  occ_e              state_d;
  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clr;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_clr;
  logic              main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;
  logic              main_valid_q;
  logic              skid_valid_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (out_fire && in_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = OCC_EMPTY;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = OCC_TWO;
          end
        end
        OCC_TWO: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = OCC_ONE;
          end
        end
        default: begin
          state_d  = OCC_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_valid_d = main_from_skid ? skid_valid_q : in_valid;
  assign main_ctrl_d  = main_from_skid ? skid_ctrl_q  : in_ctrl;
  assign main_data_d  = main_from_skid ? skid_data_q  : in_data;

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (main_clr),
    .load_i  (main_load),
    .valid_i (main_valid_d),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .valid_o (main_valid_q),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (skid_clr),
        .load_i  (skid_load),
        .valid_i (in_valid),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid_q),
        .ctrl_o  (skid_ctrl_q),
        .data_o  (skid_data_q)
      );

      // Registered ready: accept unless the stage will be full next cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != OCC_TWO);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_no_skid
      assign skid_valid_q = 1'b0;
      assign skid_ctrl_q  = '0;
      assign skid_data_q  = '0;
      assign in_ready     = ~main_valid_q | out_ready;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_clr) begin
      stall_cnt_q <= '0;
    end else if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign out_valid = main_valid_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg
// Scoreboard bench for a SKID=1 instance and a SKID=0 / CNT_W=4 instance.
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv    [2];
  logic [7:0]  ic    [2];
  logic [95:0] idat  [2];
  logic        ordy  [2];
  logic        fl    [2];
  logic        sclr  [2];

  logic        ir_s, ov_s, ir_n, ov_n;
  logic [7:0]  oc_s, oc_n;
  logic [95:0] od_s, od_n;
  logic [15:0] cnt_s;
  logic [3:0]  cnt_n;

  int checks = 0;
  int errors = 0;

  logic [103:0] q0 [$];
  logic [103:0] q1 [$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(1), .CNT_W(16)) dut_s (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir_s), .in_ctrl(ic[0]), .in_data(idat[0]),
    .out_valid(ov_s), .out_ready(ordy[0]), .out_ctrl(oc_s), .out_data(od_s),
    .stall_cnt(cnt_s), .stall_clr(sclr[0])
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(0), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir_n), .in_ctrl(ic[1]), .in_data(idat[1]),
    .out_valid(ov_n), .out_ready(ordy[1]), .out_ctrl(oc_n), .out_data(od_n),
    .stall_cnt(cnt_n), .stall_clr(sclr[1])
  );

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? ir_s : ir_n;
  endfunction

  function automatic logic vld(input int k);
    return (k == 0) ? ov_s : ov_n;
  endfunction

  // Scoreboards: push accepted payloads, pop on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
    end else begin
      if (ov_s && ordy[0]) begin
        if (q0.size() == 0) chk_eq("sb0_underflow", 0, 1);
        else chk_eq("sb0_entry", {oc_s, od_s}, q0.pop_front());
      end
      if (fl[0]) q0.delete();
      else if (iv[0] && ir_s) q0.push_back({ic[0], idat[0]});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
    end else begin
      if (ov_n && ordy[1]) begin
        if (q1.size() == 0) chk_eq("sb1_underflow", 0, 1);
        else chk_eq("sb1_entry", {oc_n, od_n}, q1.pop_front());
      end
      if (fl[1]) q1.delete();
      else if (iv[1] && ir_n) q1.push_back({ic[1], idat[1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] c, input logic [95:0] d);
    bit f;
    bit done;
    done = 1'b0;
    iv[k] = 1'b1; ic[k] = c; idat[k] = d;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      f = rdy(k);
      @(posedge clk);
      #1;
      done = f;
    end
    if (!done) chk_eq("send_timeout", 0, 1);
    iv[k] = 1'b0;
  endtask

  task automatic wait_empty(input int k);
    for (int n = 0; n < 20 && vld(k); n++) tick();
    if (vld(k)) chk_eq("drain_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ic[k] = '0; idat[k] = '0; ordy[k] = 0; fl[k] = 0; sclr[k] = 0;
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of a stalled stream
    iv[0] = 1'b1; ic[0] = 8'h11; idat[0] = 96'hAA;
    tick();
    tick();
    iv[0] = 1'b0;
    chk_eq("pre_rst_valid", ov_s, 1);
    rst = 1'b1;
    #2;
    chk_eq("rst_valid", ov_s, 0);
    chk_eq("rst_ctrl", oc_s, 0);
    chk_eq("rst_data", od_s, 0);
    chk_eq("rst_cnt", cnt_s, 0);
    chk_eq("rst_ready", ir_s, 1);
    tick();
    rst = 1'b0;
    tick();
    chk_eq("post_rst_valid", ov_s, 0);

    // Streaming flow with one-cycle latency
    ordy[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      iv[0] = 1'b1; ic[0] = 8'(i); idat[0] = 96'(i);
      chk_eq("flow_ready", ir_s, 1);
      tick();
      chk_eq("flow_valid", ov_s, 1);
      chk_eq("flow_data", od_s, i);
    end
    iv[0] = 1'b0;
    tick();
    chk_eq("flow_drain", ov_s, 0);

    // Back-pressure with skid entry
    ordy[0] = 1'b0;
    send(0, 8'h0A, 96'hA);
    send(0, 8'h0B, 96'hB);
    chk_eq("bp_ready_two", ir_s, 0);
    iv[0] = 1'b1; ic[0] = 8'h0C; idat[0] = 96'hC;
    tick();
    tick();
    chk_eq("bp_hold_ready", ir_s, 0);
    chk_eq("bp_hold_data", od_s, 96'hA);
    ordy[0] = 1'b1;
    send(0, 8'h0C, 96'hC);
    wait_empty(0);

    // Back-pressure without skid entry: ready follows out_ready directly
    ordy[1] = 1'b0;
    send(1, 8'h0A, 96'hA);
    #1;
    chk_eq("bp0_ready_lo", ir_n, 0);
    ordy[1] = 1'b1;
    #1;
    chk_eq("bp0_ready_hi", ir_n, 1);
    ordy[1] = 1'b0;
    #1;
    iv[1] = 1'b1; ic[1] = 8'h0B; idat[1] = 96'hB;
    tick();
    tick();
    chk_eq("bp0_hold_ready", ir_n, 0);
    chk_eq("bp0_hold_data", od_n, 96'hA);
    ordy[1] = 1'b1;
    send(1, 8'h0B, 96'hB);
    send(1, 8'h0C, 96'hC);
    wait_empty(1);

    // Flush while full, with a pending entry D upstream
    ordy[0] = 1'b0;
    send(0, 8'h21, 96'h21);
    send(0, 8'h22, 96'h22);
    iv[0] = 1'b1; ic[0] = 8'h2D; idat[0] = 96'h2D;
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk_eq("fl_valid", ov_s, 0);
    chk_eq("fl_ctrl", oc_s, 0);
    chk_eq("fl_data", od_s, 0);
    chk_eq("fl_ready", ir_s, 1);
    ordy[0] = 1'b1;
    repeat (3) tick();
    chk_eq("fl_no_d", ov_s, 0);

    // Flush beats a simultaneous in_fire
    ordy[0] = 1'b0;
    send(0, 8'h31, 96'h31);
    iv[0] = 1'b1; ic[0] = 8'h3D; idat[0] = 96'h3D;
    fl[0] = 1'b1;
    chk_eq("fl1_ready", ir_s, 1);
    tick();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk_eq("fl1_valid", ov_s, 0);
    ordy[0] = 1'b1;
    repeat (2) tick();
    chk_eq("fl1_no_d", ov_s, 0);

    // Flush with out_fire in the same cycle still delivers the entry
    send(0, 8'h35, 96'h35);
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    chk_eq("fl2_valid", ov_s, 0);

    // Bubble never carries control bits
    iv[0] = 1'b0; ic[0] = 8'hFF; idat[0] = '1;
    tick();
    tick();
    chk_eq("bub_ctrl", oc_s, 0);
    chk_eq("bub_valid", ov_s, 0);

    // Stall counter: clear wins over a stall, then count, flush leaves it
    ordy[0] = 1'b0;
    send(0, 8'h41, 96'h41);
    sclr[0] = 1'b1;
    tick();
    sclr[0] = 1'b0;
    chk_eq("cnt_clr", cnt_s, 0);
    repeat (5) tick();
    chk_eq("cnt_five", cnt_s, 5);
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    chk_eq("cnt_flush", cnt_s, 6);
    tick();
    chk_eq("cnt_hold", cnt_s, 6);

    // Saturation on the 4-bit counter
    ordy[1] = 1'b0;
    send(1, 8'h51, 96'h51);
    sclr[1] = 1'b1;
    tick();
    sclr[1] = 1'b0;
    repeat (20) tick();
    chk_eq("cnt_sat", cnt_n, 15);
    fl[1] = 1'b1;
    tick();
    fl[1] = 1'b0;
    tick();

    chk_eq("sb0_left", q0.size(), 0);
    chk_eq("sb1_left", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
